// File: rtl/rig_emu_pkg.sv
// Shared types and constants for the experiment rig emulator.
package rig_emu_pkg;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    FG_DELAY_S   = 4'd1,
    FG_PULSE     = 4'd2,
    ARMED        = 4'd3,
    WIRE_DELAY_S = 4'd4,
    WIRE_PULSE   = 4'd5,
    WAIT_TRIGGER = 4'd6,
    BUSY_DELAY_S = 4'd7,
    DET_BUSY     = 4'd8,
    DONE         = 4'd9
  } rig_state_t;

  localparam int unsigned ERR_EARLY_DET    = 0;
  localparam int unsigned ERR_TRIG_TIMEOUT = 1;
  localparam int unsigned ERR_TRIG_NO_WIRE = 2;

  // Saturating 16-bit increment used by the measurement counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rig_phase_gen.sv
// Phase reference square wave and the clocks-since-last-phase-rise counter.
module rig_phase_gen
  import rig_emu_pkg::*;
#(
  parameter int unsigned PHASE_PERIOD = 2000,
  parameter int unsigned PHASE_HIGH   = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        phase_enable,
  output logic        phase_signal,
  output logic [15:0] phase_count
);

  localparam int unsigned   PCW     = $clog2(PHASE_PERIOD);
  localparam logic [PCW-1:0] PC_LAST = PCW'(PHASE_PERIOD - 1);
  localparam logic [PCW-1:0] PC_HIGH = PCW'(PHASE_HIGH);

  logic [PCW-1:0] pc_q, pc_d;
  logic           phase_q, phase_d;
  logic           phase_prev_q, phase_prev_d;
  logic [15:0]    off_q, off_d;

  // Next-state for the period counter, registered phase output and offset counter.
  always_comb begin
    pc_d    = '0;
    phase_d = 1'b0;
    if (phase_enable) begin
      pc_d    = (pc_q == PC_LAST) ? '0 : pc_q + PCW'(1);
      phase_d = (pc_q < PC_HIGH);
    end
    phase_prev_d = phase_q;
    off_d        = (phase_q && !phase_prev_q) ? '0 : sat_inc16(off_q);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q         <= '0;
      phase_q      <= 1'b0;
      phase_prev_q <= 1'b0;
      off_q        <= '0;
    end else begin
      pc_q         <= pc_d;
      phase_q      <= phase_d;
      phase_prev_q <= phase_prev_d;
      off_q        <= off_d;
    end
  end

  assign phase_signal = phase_q;
  assign phase_count  = off_q;

endmodule

// File: rtl/experiment_rig_emulator.sv
// Closed-loop stand-in for the rig: answers sequencer outputs and measures detonation timing.
module experiment_rig_emulator
  import rig_emu_pkg::*;
#(
  parameter int unsigned FG_DELAY        = 1000,
  parameter int unsigned PULSE_WIDTH     = 10,
  parameter int unsigned PHASE_PERIOD    = 2000,
  parameter int unsigned PHASE_HIGH      = 1000,
  parameter int unsigned WIRE_DELAY      = 20,
  parameter int unsigned BUSY_DELAY      = 5,
  parameter int unsigned BUSY_TIME       = 300,
  parameter int unsigned TRIGGER_TIMEOUT = 10000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_signal,
  input  logic        detonation_signal,
  input  logic        output_trigger,
  input  logic        phase_enable,
  output logic        fg_signal,
  output logic        phase_signal,
  output logic        wire_signal,
  output logic        detector_ready,
  output logic [3:0]  rig_state,
  output logic [15:0] detonation_width,
  output logic [15:0] phase_offset,
  output logic [2:0]  error_flags
);

  localparam logic [31:0] FG_LAST = 32'(FG_DELAY - 1);
  localparam logic [31:0] PW_LAST = 32'(PULSE_WIDTH - 1);
  localparam logic [31:0] WD_LAST = 32'(WIRE_DELAY - 1);
  localparam logic [31:0] BD_LAST = 32'(BUSY_DELAY - 1);
  localparam logic [31:0] BT_LAST = 32'(BUSY_TIME - 1);
  localparam logic [31:0] TO_LAST = 32'(TRIGGER_TIMEOUT - 1);

  logic [1:0]  start_h_q, start_h_d, det_h_q, det_h_d, trig_h_q, trig_h_d;
  rig_state_t  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        fg_q, fg_d, wire_q, wire_d, ready_q, ready_d;
  logic [15:0] wcnt_q, wcnt_d, width_q, width_d, offset_q, offset_d;
  logic [2:0]  err_q, err_d;
  logic [15:0] phase_count;
  logic        start_rise, det_rise, det_fall, trig_rise;

  rig_phase_gen #(
    .PHASE_PERIOD(PHASE_PERIOD),
    .PHASE_HIGH  (PHASE_HIGH)
  ) u_phase_gen (
    .clock       (clock),
    .reset       (reset),
    .phase_enable(phase_enable),
    .phase_signal(phase_signal),
    .phase_count (phase_count)
  );

  assign start_rise = (start_h_q == 2'b01);
  assign det_rise   = (det_h_q == 2'b01);
  assign det_fall   = (det_h_q == 2'b10);
  assign trig_rise  = (trig_h_q == 2'b01);

  // Input histories plus detonation width and phase offset measurement.
  always_comb begin
    start_h_d = {start_h_q[0], start_signal};
    det_h_d   = {det_h_q[0], detonation_signal};
    trig_h_d  = {trig_h_q[0], output_trigger};
    wcnt_d    = wcnt_q;
    width_d   = width_q;
    offset_d  = offset_q;
    // The rise cycle already has h[0]=1, so the cleared count starts at one.
    if (det_rise)        wcnt_d = 16'd1;
    else if (det_h_q[0]) wcnt_d = sat_inc16(wcnt_q);
    if (det_fall) width_d  = wcnt_q;
    if (det_rise) offset_d = phase_count;
  end

  // Run sequencing FSM, pulse outputs and sticky error flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 32'd1;
    fg_d    = fg_q;
    wire_d  = wire_q;
    ready_d = ready_q;
    err_d   = err_q;
    if (det_rise && state_q != ARMED) err_d[ERR_EARLY_DET] = 1'b1;
    if (trig_rise && !(state_q inside {WAIT_TRIGGER, BUSY_DELAY_S, DET_BUSY}))
      err_d[ERR_TRIG_NO_WIRE] = 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_rise) state_d = FG_DELAY_S;
      end
      FG_DELAY_S:
        if (cnt_q == FG_LAST) begin cnt_d = '0; fg_d = 1'b1; state_d = FG_PULSE; end
      FG_PULSE:
        if (cnt_q == PW_LAST) begin cnt_d = '0; fg_d = 1'b0; state_d = ARMED; end
      ARMED: begin
        cnt_d = '0;
        if (det_rise) state_d = WIRE_DELAY_S;
      end
      WIRE_DELAY_S:
        if (cnt_q == WD_LAST) begin cnt_d = '0; wire_d = 1'b1; state_d = WIRE_PULSE; end
      WIRE_PULSE:
        if (cnt_q == PW_LAST) begin cnt_d = '0; wire_d = 1'b0; state_d = WAIT_TRIGGER; end
      WAIT_TRIGGER:
        // Level test: a fresh rise and a trigger already high on entry both start the detector.
        if (trig_h_q[0]) begin
          cnt_d   = '0;
          state_d = BUSY_DELAY_S;
        end else if (cnt_q == TO_LAST) begin
          cnt_d                   = '0;
          err_d[ERR_TRIG_TIMEOUT] = 1'b1;
          state_d                 = DONE;
        end
      BUSY_DELAY_S:
        if (cnt_q == BD_LAST) begin cnt_d = '0; ready_d = 1'b0; state_d = DET_BUSY; end
      DET_BUSY:
        if (cnt_q == BT_LAST) begin cnt_d = '0; ready_d = 1'b1; state_d = DONE; end
      DONE: begin
        cnt_d = '0;
        if (!start_h_q[0]) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        fg_d    = 1'b0;
        wire_d  = 1'b0;
        ready_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // All registers, synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      start_h_q <= '0;
      det_h_q   <= '0;
      trig_h_q  <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      fg_q      <= 1'b0;
      wire_q    <= 1'b0;
      ready_q   <= 1'b1;
      wcnt_q    <= '0;
      width_q   <= '0;
      offset_q  <= '0;
      err_q     <= '0;
    end else begin
      start_h_q <= start_h_d;
      det_h_q   <= det_h_d;
      trig_h_q  <= trig_h_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fg_q      <= fg_d;
      wire_q    <= wire_d;
      ready_q   <= ready_d;
      wcnt_q    <= wcnt_d;
      width_q   <= width_d;
      offset_q  <= offset_d;
      err_q     <= err_d;
    end
  end

  assign fg_signal        = fg_q;
  assign wire_signal      = wire_q;
  assign detector_ready   = ready_q;
  assign rig_state        = state_q;
  assign detonation_width = width_q;
  assign phase_offset     = offset_q;
  assign error_flags      = err_q;

endmodule

// File: tb/tb_experiment_rig_emulator.sv
// Self-checking bench: randomized runs compared against event times derived from the rig's delay rules.
module tb_experiment_rig_emulator;
  import rig_emu_pkg::*;

  localparam int FG_D = 10, PW = 3, PERIOD = 20, PHIGH = 10, WIRE_D = 4;
  localparam int BUSY_D = 2, BUSY_T = 8, TMO = 50;
  localparam int SYNC = 2;  // input change -> first effect

  logic clock = 1'b0;
  logic reset, start_signal, detonation_signal, output_trigger, phase_enable;
  logic fg_signal, phase_signal, wire_signal, detector_ready;
  logic [3:0]  rig_state;
  logic [15:0] detonation_width, phase_offset;
  logic [2:0]  error_flags;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  experiment_rig_emulator #(
    .FG_DELAY(FG_D), .PULSE_WIDTH(PW), .PHASE_PERIOD(PERIOD), .PHASE_HIGH(PHIGH),
    .WIRE_DELAY(WIRE_D), .BUSY_DELAY(BUSY_D), .BUSY_TIME(BUSY_T), .TRIGGER_TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset), .start_signal(start_signal),
    .detonation_signal(detonation_signal), .output_trigger(output_trigger),
    .phase_enable(phase_enable), .fg_signal(fg_signal), .phase_signal(phase_signal),
    .wire_signal(wire_signal), .detector_ready(detector_ready), .rig_state(rig_state),
    .detonation_width(detonation_width), .phase_offset(phase_offset),
    .error_flags(error_flags)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Edge-time recorder: cycle index of the last edge after which each output changed.
  int fg_rise = -1, fg_fall = -1, wire_rise = -1, wire_fall = -1;
  int rdy_fall = -1, rdy_rise = -1, done_at = -1;
  logic fg_p = 1'b0, wire_p = 1'b0, rdy_p = 1'b1;
  logic [3:0] st_p = 4'd0;
  always @(negedge clock) begin
    if (fg_signal && !fg_p) fg_rise = cyc;
    if (!fg_signal && fg_p) fg_fall = cyc;
    if (wire_signal && !wire_p) wire_rise = cyc;
    if (!wire_signal && wire_p) wire_fall = cyc;
    if (!detector_ready && rdy_p) rdy_fall = cyc;
    if (detector_ready && !rdy_p) rdy_rise = cyc;
    if (rig_state == DONE && st_p != DONE) done_at = cyc;
    fg_p = fg_signal; wire_p = wire_signal; rdy_p = detector_ready; st_p = rig_state;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input rig_state_t target, input int budget, input string name);
    int n = 0;
    while (rig_state !== target && n < budget) begin tick(); n++; end
    n_checks++;
    if (rig_state !== target) begin
      n_fail++;
      $display("FAIL %s: state %0d, required %0d within %0d clocks", name, rig_state, target, budget);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; start_signal = 1'b0; detonation_signal = 1'b0; output_trigger = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // One complete run; expected event times follow from the configured delays.
  task automatic run_nominal(input int w, input int k, input int tdel, input bit early,
                             input logic [2:0] exp_err);
    int s, p, d, t, x, n;
    logic prev;
    start_signal = 1'b1; s = cyc;
    if (early) begin
      repeat (3) tick();
      detonation_signal = 1'b1; tick(); tick(); detonation_signal = 1'b0;
      n_checks++;
      if (error_flags !== 3'b001 || rig_state !== FG_DELAY_S) begin
        n_fail++;
        $display("FAIL early_det: flags %b state %0d, required 001 state %0d", error_flags, rig_state, FG_DELAY_S);
      end
      repeat (3) tick();
      n_checks++;
      if (detonation_width !== 16'd2) begin
        n_fail++; $display("FAIL early_width: got %0d, required 2", detonation_width);
      end
    end
    wait_state(ARMED, 40, "reach_armed");
    // Align the detonation k clocks after an observed phase rise.
    prev = phase_signal; n = 0;
    while (!(phase_signal && !prev) && n < PERIOD + 5) begin prev = phase_signal; tick(); n++; end
    p = cyc;
    repeat (k) tick();
    detonation_signal = 1'b1; d = cyc;
    repeat (w) tick();
    detonation_signal = 1'b0;
    while (cyc < d + SYNC + WIRE_D + PW + tdel) tick();
    output_trigger = 1'b1; t = cyc;
    wait_state(DONE, 60, "reach_done");
    tick(); tick();
    n_checks++;
    if (p + k !== d) begin n_fail++; $display("FAIL phase_align: detonation at %0d, required %0d", d, p + k); end
    n_checks++;
    if (fg_rise !== s + SYNC + FG_D || fg_fall !== s + SYNC + FG_D + PW) begin
      n_fail++; $display("FAIL fg_pulse: rise %0d fall %0d, required %0d %0d", fg_rise, fg_fall, s + SYNC + FG_D, s + SYNC + FG_D + PW);
    end
    n_checks++;
    if (wire_rise !== d + SYNC + WIRE_D || wire_fall !== d + SYNC + WIRE_D + PW) begin
      n_fail++; $display("FAIL wire_pulse: rise %0d fall %0d, required %0d %0d", wire_rise, wire_fall, d + SYNC + WIRE_D, d + SYNC + WIRE_D + PW);
    end
    n_checks++;
    if (rdy_fall !== t + SYNC + BUSY_D || rdy_rise !== t + SYNC + BUSY_D + BUSY_T) begin
      n_fail++; $display("FAIL ready_busy: fall %0d rise %0d, required %0d %0d", rdy_fall, rdy_rise, t + SYNC + BUSY_D, t + SYNC + BUSY_D + BUSY_T);
    end
    n_checks++;
    if (done_at !== t + SYNC + BUSY_D + BUSY_T) begin
      n_fail++; $display("FAIL done_time: got %0d, required %0d", done_at, t + SYNC + BUSY_D + BUSY_T);
    end
    n_checks++;
    if (detonation_width !== 16'(w)) begin
      n_fail++; $display("FAIL det_width: got %0d, required %0d", detonation_width, w);
    end
    n_checks++;
    if (phase_offset !== 16'(k)) begin
      n_fail++; $display("FAIL phase_offset: got %0d, required %0d", phase_offset, k);
    end
    n_checks++;
    if (error_flags !== exp_err) begin
      n_fail++; $display("FAIL run_flags: got %b, required %b", error_flags, exp_err);
    end
    output_trigger = 1'b0; start_signal = 1'b0; x = cyc;
    tick();
    n_checks++;
    if (rig_state !== DONE) begin
      n_fail++; $display("FAIL done_hold: state %0d at +1, required %0d", rig_state, DONE);
    end
    tick();
    n_checks++;
    if (rig_state !== IDLE || cyc !== x + SYNC) begin
      n_fail++; $display("FAIL back_to_idle: state %0d, required %0d", rig_state, IDLE);
    end
  endtask

  task automatic test_reset();
    phase_enable = 1'b0;
    do_reset();
    n_checks++;
    if (detector_ready !== 1'b1 || fg_signal !== 1'b0 || wire_signal !== 1'b0 || phase_signal !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: ready %b fg %b wire %b phase %b, required 1 0 0 0", detector_ready, fg_signal, wire_signal, phase_signal);
    end
    n_checks++;
    if (rig_state !== IDLE || error_flags !== 3'b000) begin
      n_fail++; $display("FAIL reset_state: state %0d flags %b, required 0 000", rig_state, error_flags);
    end
    n_checks++;
    if (detonation_width !== 16'd0 || phase_offset !== 16'd0) begin
      n_fail++; $display("FAIL reset_meas: width %0d offset %0d, required 0 0", detonation_width, phase_offset);
    end
  endtask

  task automatic test_phase();
    int hi, lo;
    phase_enable = 1'b1;
    tick();
    n_checks++;
    if (phase_signal !== 1'b1) begin n_fail++; $display("FAIL phase_start: got %b, required 1", phase_signal); end
    repeat (2) begin
      while (phase_signal !== 1'b0) tick();
      while (phase_signal !== 1'b1) tick();
      hi = 0; lo = 0;
      while (phase_signal === 1'b1 && hi < 100) begin hi++; tick(); end
      while (phase_signal === 1'b0 && lo < 100) begin lo++; tick(); end
      n_checks++;
      if (hi !== PHIGH || lo !== PERIOD - PHIGH) begin
        n_fail++; $display("FAIL phase_duty: high %0d low %0d, required %0d %0d", hi, lo, PHIGH, PERIOD - PHIGH);
      end
    end
    phase_enable = 1'b0;
    tick();
    n_checks++;
    if (phase_signal !== 1'b0) begin n_fail++; $display("FAIL phase_disable: got %b, required 0", phase_signal); end
    phase_enable = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    repeat (3)
      run_nominal($urandom_range(8, 1), $urandom_range(15, 0), $urandom_range(20, 0), 1'b0, 3'b000);
  endtask

  task automatic test_early_detonation();
    do_reset();
    run_nominal($urandom_range(8, 1), $urandom_range(15, 0), $urandom_range(20, 0), 1'b1, 3'b001);
  endtask

  task automatic test_timeout();
    int d;
    do_reset();
    start_signal = 1'b1;
    wait_state(ARMED, 40, "timeout_armed");
    detonation_signal = 1'b1; d = cyc;
    repeat (3) tick();
    detonation_signal = 1'b0;
    wait_state(DONE, 80, "timeout_done");
    tick(); tick();
    n_checks++;
    if (done_at !== d + SYNC + WIRE_D + PW + TMO) begin
      n_fail++; $display("FAIL timeout_time: got %0d, required %0d", done_at, d + SYNC + WIRE_D + PW + TMO);
    end
    n_checks++;
    if (error_flags !== 3'b010 || rdy_fall >= d) begin
      n_fail++; $display("FAIL timeout_flags: flags %b ready_fall %0d, required 010 and no busy", error_flags, rdy_fall);
    end
    start_signal = 1'b0;
    tick(); tick();
  endtask

  task automatic test_trigger_no_wire();
    do_reset();
    output_trigger = 1'b1;
    tick();
    n_checks++;
    if (error_flags !== 3'b000) begin n_fail++; $display("FAIL trig_early_flag: got %b, required 000", error_flags); end
    tick();
    n_checks++;
    if (error_flags !== 3'b100 || rig_state !== IDLE) begin
      n_fail++; $display("FAIL trig_no_wire: flags %b state %0d, required 100 0", error_flags, rig_state);
    end
    output_trigger = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    start_signal = 1'b1;
    repeat (3) tick();
    detonation_signal = 1'b1; tick(); tick(); detonation_signal = 1'b0;
    wait_state(ARMED, 40, "midrst_armed");
    detonation_signal = 1'b1; tick(); tick(); detonation_signal = 1'b0;
    wait_state(WAIT_TRIGGER, 30, "midrst_wait");
    output_trigger = 1'b1;
    wait_state(DET_BUSY, 20, "midrst_busy");
    tick();
    n_checks++;
    if (error_flags !== 3'b001 || detector_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_pre: flags %b ready %b, required 001 0", error_flags, detector_ready);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (detector_ready !== 1'b1 || rig_state !== IDLE || error_flags !== 3'b000) begin
      n_fail++; $display("FAIL midrst: ready %b state %0d flags %b, required 1 0 000", detector_ready, rig_state, error_flags);
    end
    n_checks++;
    if (detonation_width !== 16'd0 || phase_offset !== 16'd0 || fg_signal !== 1'b0 || wire_signal !== 1'b0) begin
      n_fail++; $display("FAIL midrst_meas: width %0d offset %0d fg %b wire %b, required all 0", detonation_width, phase_offset, fg_signal, wire_signal);
    end
    reset = 1'b0; start_signal = 1'b0; output_trigger = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; start_signal = 1'b0; detonation_signal = 1'b0;
    output_trigger = 1'b0; phase_enable = 1'b0;
    test_reset();
    test_phase();
    test_back_to_back();
    test_early_detonation();
    test_timeout();
    test_trigger_no_wire();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/experiment_rig_emulator.md
Name: experiment_rig_emulator

Overview:
- Simulation and bench-top stand-in for the physical rig that drives the experiment sequencer: the FG opto sensor, the phase reference, the exploding-wire sensor and the detector.
- Answers the sequencer's start, detonation and trigger outputs with fg_signal, phase_signal, wire_signal and detector_ready, using configurable timing.
- Measures the detonation pulse width and its offset from the last phase front, so calibration runs can check sequencer timing in closed loop.

Parameters:
- FG_DELAY, 1000: clocks from a detected start rise to fg_signal going high.
- PULSE_WIDTH, 10: high time in clocks of the fg_signal and wire_signal pulses (>=1).
- PHASE_PERIOD, 2000: phase square-wave period in clocks (>=2).
- PHASE_HIGH, 1000: phase_signal high clocks per period (1..PHASE_PERIOD-1).
- WIRE_DELAY, 20: clocks from a detected detonation rise to wire_signal going high.
- BUSY_DELAY, 5: clocks from a detected output_trigger rise to detector_ready going low.
- BUSY_TIME, 300: clocks detector_ready is held low.
- TRIGGER_TIMEOUT, 10000: maximum clocks to wait for output_trigger after the wire pulse.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous reset, active-high
- start_signal  in  1  sequencer start request
- detonation_signal  in  1  sequencer detonation pulse
- output_trigger  in  1  sequencer detector trigger (level)
- phase_enable  in  1  runs the phase generator
- fg_signal  out  1  FG opto pulse
- phase_signal  out  1  phase reference square wave
- wire_signal  out  1  wire-burst pulse
- detector_ready  out  1  1 = detector idle, 0 = busy
- rig_state  out  4  current FSM state encoding
- detonation_width  out  16  high time of the last detonation pulse, saturating
- phase_offset  out  16  clocks from the last phase rise to the detonation rise, saturating
- error_flags  out  3  sticky: [0] early detonation, [1] trigger timeout, [2] trigger without wire

Behaviour:
- Reset values (on reset=1 at a clock edge): all outputs 0 except detector_ready=1. rig_state=IDLE, all counters 0, error_flags cleared. Reset mid-operation aborts the run immediately.
- Input edge detection:
  - Each input passes through a 2-stage history: h <= {h[0], in}.
  - A rise is h==2'b01.
  - The FSM acts on the clock edge after the rise is visible, so an input change produces its first effect 2 clocks later.
- Phase generator:
  - Counter pc runs 0..PHASE_PERIOD-1 and wraps to 0.
  - phase_signal = (pc < PHASE_HIGH) & phase_enable, registered.
  - phase_enable=0 holds pc at 0 and forces phase_signal=0.
- phase_offset:
  - A counter clears on each phase_signal rise (internal register, no synchronizer) and increments otherwise, saturating at 16'hFFFF.
  - Its value is latched into phase_offset on a detected detonation rise.
- detonation_width:
  - A counter clears on the detonation rise and counts the clocks where h[0]=1, saturating.
  - It is latched into detonation_width on the detonation fall (h==2'b10).
- FSM states: IDLE, FG_DELAY_S, FG_PULSE, ARMED, WIRE_DELAY_S, WIRE_PULSE, WAIT_TRIGGER, BUSY_DELAY_S, DET_BUSY, DONE.
  - IDLE: start rise -> FG_DELAY_S, counter=0.
  - FG_DELAY_S: count to FG_DELAY-1, then -> FG_PULSE with fg_signal=1.
  - FG_PULSE: after PULSE_WIDTH clocks, fg_signal=0 -> ARMED.
  - ARMED: detonation rise -> WIRE_DELAY_S.
  - WIRE_DELAY_S: after WIRE_DELAY clocks, wire_signal=1 -> WIRE_PULSE.
  - WIRE_PULSE: after PULSE_WIDTH clocks, wire_signal=0 -> WAIT_TRIGGER.
  - WAIT_TRIGGER:
    - A trigger rise -> BUSY_DELAY_S.
    - A trigger already high on entry also counts as a rise.
    - If no trigger arrives within TRIGGER_TIMEOUT clocks, set error_flags[1] -> DONE.
  - BUSY_DELAY_S: after BUSY_DELAY clocks, detector_ready=0 -> DET_BUSY.
  - DET_BUSY: after BUSY_TIME clocks, detector_ready=1 -> DONE.
  - DONE: start_signal sampled 0 -> IDLE.
- Error flags (sticky):
  - A detonation rise in any state other than ARMED sets error_flags[0]. The FSM does not change state, and the width/offset measurements still run.
  - A trigger rise outside WAIT_TRIGGER, BUSY_DELAY_S and DET_BUSY sets error_flags[2].
- Simultaneous events: a start rise outside IDLE is ignored.
- Unused state encodings -> IDLE.

Decomposition:
- Package rig_emu_pkg holds:
  - the rig_state_t enum (4-bit), with encodings in the state order above;
  - error bit index constants ERR_EARLY_DET=0, ERR_TRIG_TIMEOUT=1, ERR_TRIG_NO_WIRE=2.
- One sub-module, rig_phase_gen: phase counter, phase_signal and the offset counter.

Test Plan (parameters: FG_DELAY=10, PULSE_WIDTH=3, PHASE_PERIOD=20, PHASE_HIGH=10, WIRE_DELAY=4, BUSY_DELAY=2, BUSY_TIME=8, TRIGGER_TIMEOUT=50):
- Reset: assert reset 2 clocks -> detector_ready=1, all other outputs 0, rig_state=IDLE, error_flags=0.
- Nominal run:
  - Stimulus: start rise; detonation high 5 clocks when ARMED; trigger rise after the wire pulse.
  - Response: fg_signal high exactly 3 clocks starting 12 clocks after the start rise; wire_signal high 3 clocks starting 6 clocks after the detonation rise; detector_ready low 8 clocks; detonation_width=5; state DONE, then IDLE once start drops.
- Phase: phase_enable=1 -> phase_signal 10 high/10 low clocks; a detonation rise 7 clocks after a phase rise -> phase_offset=7 (±1, per the documented sampling latency).
- Timeout: no trigger after the wire pulse -> error_flags=3'b010 and rig_state=DONE after 50 clocks.
- Early detonation: detonation pulse in FG_DELAY_S -> error_flags[0]=1, state unchanged; the run continues normally.
- Reset mid-run: reset during DET_BUSY -> detector_ready=1 and rig_state=IDLE on the next edge; sticky flags cleared.
